// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester and register-bank write port bundle for reg_write_arbiter
interface reg_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               wr_ready;
    logic               we;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [NREQ-1:0]    gnt;
    logic [PW-1:0]      owner;
    modport master (
        output req, req_addr, req_data, wr_ready,
        input  we, wr_addr, wr_data, gnt, owner
    );
    modport slave (
        input  req, req_addr, req_data, wr_ready,
        output we, wr_addr, wr_data, gnt, owner
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one registered bank write port among NREQ requesters
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input logic                clk,
    input logic                rst_n,
    reg_write_arbiter_if.slave io_bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr, r_owner, w_win;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [NREQ-1:0] w_elig;
    logic            w_we, w_found, w_load;
    int              j;
    assign w_we = (r_state == ISSUE);
    // the owner's req is still high on its completing edge, so it sits out that search
    assign w_elig = io_bus.req & ~(NREQ'(w_we) << r_owner);
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (w_elig[PW'(j)]) begin
                w_found = 1'b1;
                w_win   = PW'(j);
            end
        end
    end
    assign w_load = w_found & (~w_we | io_bus.wr_ready);
    always_comb begin
        w_state_nxt = r_state;
        if (!w_we || io_bus.wr_ready)
            w_state_nxt = w_found ? ISSUE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_addr  <= AW'(io_bus.req_addr >> (int'(w_win) * AW));
            r_data  <= DW'(io_bus.req_data >> (int'(w_win) * DW));
            r_owner <= w_win;
            r_ptr   <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
        end
    end
    assign io_bus.we      = w_we;
    assign io_bus.wr_addr = r_addr;
    assign io_bus.wr_data = r_data;
    assign io_bus.owner   = r_owner;
    assign io_bus.gnt     = NREQ'(w_we & io_bus.wr_ready) << r_owner;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed stimulus with a round-robin reference model checked every cycle
module tb_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;
    logic clk = 1'b0;
    logic rst_n;
    int tests = 0;
    int fails = 0;
    reg_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    // Reference model: an in-flight write slot plus a rotating priority start
    logic        m_we;
    int          m_owner, m_ptr, m_nxt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_log[$];
    function automatic int pick(input logic [NREQ-1:0] r, input int p, input bit ex, input int o);
        for (int d = 0; d < NREQ; d++) begin
            int i = (p + d) % NREQ;
            if (r[i] && !(ex && i == o)) return i;
        end
        return -1;
    endfunction
    always_comb m_nxt = pick(bus.req, m_ptr, m_we, m_owner);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we <= 1'b0; m_owner <= 0; m_ptr <= 0; m_addr <= '0; m_data <= '0;
        end else if (!m_we || bus.wr_ready) begin
            if (m_we) m_log.push_back(m_owner);
            m_we <= (m_nxt >= 0);
            if (m_nxt >= 0) begin
                m_owner <= m_nxt;
                m_ptr   <= (m_nxt + 1) % NREQ;
                m_addr  <= bus.req_addr[m_nxt*AW +: AW];
                m_data  <= bus.req_data[m_nxt*DW +: DW];
            end
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_we", bus.we, m_we);
            chk("cmp_addr", bus.wr_addr, m_addr);
            chk("cmp_data", bus.wr_data, m_data);
            chk("cmp_owner", bus.owner, m_owner);
            chk("cmp_gnt", bus.gnt, (m_we && bus.wr_ready) ? (1 << m_owner) : 0);
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        m_log.delete();
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int rr[6] = '{0, 1, 2, 3, 0, 1};
        bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.wr_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_we", bus.we, 0);
        chk("rst_gnt", bus.gnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        set_req(1, 3'd7, 8'h5A);
        bus.req = 4'b0010;
        tick();
        chk("abort_we_pre", bus.we, 1);
        chk("abort_owner_pre", bus.owner, 1);
        bus.wr_ready = 1'b1;
        #1 chk("abort_gnt_pre", bus.gnt, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("abort_we", bus.we, 0);
        chk("abort_addr", bus.wr_addr, 0);
        chk("abort_data", bus.wr_data, 0);
        chk("abort_owner", bus.owner, 0);
        chk("abort_gnt", bus.gnt, 0);
        bus.req = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_we", bus.we, 0);
        set_req(0, 3'd3, 8'hA5);
        bus.req = 4'b0001;
        tick();
        chk("single_we", bus.we, 1);
        chk("single_addr", bus.wr_addr, 3);
        chk("single_data", bus.wr_data, 8'hA5);
        chk("single_gnt", bus.gnt, 4'b0001);
        tick();
        bus.req = '0;
        chk("single_idle_we", bus.we, 0);
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 4), DW'(8'hC0 + i));
        bus.req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_owner", bus.owner, rr[n]);
            chk("rr_we", bus.we, 1);
            chk("rr_gnt", bus.gnt, 1 << rr[n]);
            chk("rr_data", bus.wr_data, 8'hC0 + rr[n]);
        end
        tick();
        bus.req = '0;
        tick(); tick();
        chk("rr_log_len", (m_log.size() >= 6) ? 1 : 0, 1);
        for (int n = 0; n < 6 && n < m_log.size(); n++) chk("rr_model_log", m_log[n], rr[n]);
        do_reset();
        bus.wr_ready = 1'b0;
        set_req(1, 3'd2, 8'h11);
        set_req(2, 3'd6, 8'h22);
        bus.req = 4'b0110;
        tick();
        for (int n = 0; n < 3; n++) begin
            chk("bp_owner", bus.owner, 1);
            chk("bp_we", bus.we, 1);
            chk("bp_gnt", bus.gnt, 0);
            chk("bp_addr", bus.wr_addr, 2);
            chk("bp_data", bus.wr_data, 8'h11);
            if (n < 2) tick();
        end
        bus.wr_ready = 1'b1;
        #1 chk("bp_release_gnt", bus.gnt, 4'b0010);
        tick();
        bus.req = 4'b0100;
        chk("bp_next_owner", bus.owner, 2);
        chk("bp_next_gnt", bus.gnt, 4'b0100);
        chk("bp_next_data", bus.wr_data, 8'h22);
        tick();
        bus.req = '0;
        chk("bp_idle_we", bus.we, 0);
        do_reset();
        set_req(2, 3'd5, 8'h20);
        bus.req = 4'b0100;
        tick();
        chk("cont_we0", bus.we, 1);
        chk("cont_gnt0", bus.gnt, 4'b0100);
        chk("cont_data0", bus.wr_data, 8'h20);
        tick();
        set_req(2, 3'd5, 8'h21);
        chk("cont_we1", bus.we, 0);
        chk("cont_gnt1", bus.gnt, 0);
        tick();
        chk("cont_we2", bus.we, 1);
        chk("cont_data2", bus.wr_data, 8'h21);
        chk("cont_gnt2", bus.gnt, 4'b0100);
        tick();
        chk("cont_we3", bus.we, 0);
        set_req(3, 3'd1, 8'h33);
        bus.req = 4'b1000;
        tick();
        chk("wrap_owner3", bus.owner, 3);
        set_req(1, 3'd4, 8'h44);
        bus.req = 4'b1010;
        tick();
        chk("wrap_owner1", bus.owner, 1);
        chk("wrap_data1", bus.wr_data, 8'h44);
        set_req(3, 3'd1, 8'h34);
        bus.req = 4'b1000;
        tick();
        chk("wrap_owner3b", bus.owner, 3);
        chk("wrap_data3b", bus.wr_data, 8'h34);
        bus.req = '0;
        tick(); tick();
        chk("wrap_idle_we", bus.we, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the flip-flop register bank among NREQ requesters. Each requester presents a write request (address and data). The arbiter selects one request per transfer, drives the bank's write port from registers, and returns a one-cycle grant when the bank accepts the write. It sits between the datapath write sources and the register bank.

## Interface
- NREQ, 4, number of requesters (≥2)
- AW, 3, register address width
- DW, 8, register data width

- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset; Reset=0 clears all state immediately
- req  in  NREQ  request, one bit per requester
- req_addr  in  NREQ*AW  requester i address at bits [i*AW +: AW]
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- wr_ready  in  1  bank accepts the presented write this cycle
- we  out  1  write enable to bank (registered)
- wr_addr  out  AW  write address (registered)
- wr_data  out  DW  write data (registered)
- gnt  out  NREQ  one-hot grant, combinational: gnt[owner] = we & wr_ready
- owner  out  log2(NREQ)  index of requester currently being served (registered)

## Operation
- States: IDLE (we=0), ISSUE (we=1, write presented, waiting for wr_ready).
- Internal pointer ptr (log2(NREQ) bits) marks the highest-priority index. The search order is ptr, ptr+1, … mod NREQ. First eligible req wins.
- IDLE:
  - any req=1 → load winner's addr/data into wr_addr/wr_data, owner=winner, ptr=winner+1 mod NREQ, go to ISSUE.
  - else stay in IDLE.
- ISSUE:
  - wr_ready=0 → hold all outputs; stay in ISSUE. New requests are not considered.
  - wr_ready=1 → write completes on this edge and gnt[owner]=1 during this cycle. On the same edge, the arbiter selects the next winner with owner excluded from eligibility, because its req is still high at that edge.
    - Winner found → reload outputs, update owner/ptr, stay in ISSUE (back-to-back).
    - None found → IDLE, we=0.
- Requester protocol:
  - Hold req, addr and data stable from assertion until the cycle gnt[i]=1.
  - Drop req, or present a new request, after that edge.
- Request withdrawn while pending (protocol violation): the registered write still completes with the captured addr/data, and gnt still pulses.
- wr_addr/wr_data retain their last values in IDLE; only we returns to 0.
- ptr wrap: winner NREQ-1 → ptr=0.

## Timing
- Reset (Reset=0, asynchronous): state=IDLE, we=0, wr_addr=0, wr_data=0, owner=0, ptr=0, hence gnt=0.
- Reset asserted during ISSUE aborts the write: no gnt, and bank sees we=0 immediately.
- Reset released: first request sampled at the first rising edge with Reset=1.
- Latency: req sampled at edge k (IDLE) → we=1 after edge k → gnt in the same cycle if wr_ready=1 → write stored at edge k+1.
- Throughput: 1 write/cycle when wr_ready is held high and multiple requesters are active.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ grants.
- A single continuous requester is granted at most every other cycle, because of the owner exclusion (ISSUE → IDLE → ISSUE).
- Simultaneous req rise on several inputs: the lowest search distance from ptr wins. ptr=0 after reset → index 0 first.
- gnt never asserts while we=0. gnt is never multi-hot.

## Test plan
- Reset: drive Reset=0 mid-ISSUE with we=1 → we, wr_addr, wr_data, owner, gnt all 0 without a clock edge. After release with no req, we stays 0.
- Single write: NREQ=4, req=0001, addr0=3, data0=8'hA5, wr_ready=1 → next cycle we=1, wr_addr=3, wr_data=A5, gnt=0001. Drop req → following cycle we=0.
- Round-robin: req=1111 held, wr_ready=1, distinct addr/data per requester → owner sequence 0,1,2,3,0,1 with we=1 every cycle. Each gnt matches owner and the written addr/data.
- Backpressure: req=0110, wr_ready=0 for 3 cycles → owner=1 and we, wr_addr, wr_data stable for 3 cycles, gnt=0. Raise wr_ready → gnt=0010, then owner=2 next cycle.
- Single continuous requester: req=0100 held with new data after each gnt → we pattern 1,0,1,0; gnt=0100 on each we=1 cycle.
- Wrap and priority: after a grant to requester 3 (ptr=0), assert req=1010 → owner=1. Then the next winner is 3.
